draw_rect_ctl: RTL and testbench
================================

# draw_rect_ctl

Frame-rate motion controller for the sprite rectangle drawer. It generates the `xpos`/`ypos` pair consumed by the rectangle/sprite draw stage. While idle, the rectangle follows the mouse. A left click drops it under constant per-frame acceleration to the screen floor. All position updates are applied once per frame, on the rising edge of vertical blanking, so the draw stage never sees a position change mid-frame.

## Interface
- `SCREEN_H`, default 600: visible lines.
- `RECT_H`, default 64: rectangle height; `FLOOR = SCREEN_H - RECT_H` (536).
- `ACCEL`, default 1: velocity increment per frame, px/frame².
- `VMAX`, default 32: velocity saturation, px/frame.
- `MIN_BOUNCE`, default 4: minimum post-loss velocity that still bounces.
- `pclk` in 1: pixel clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `vblnk_in` in 1: vertical blanking from the timing chain; its rising edge is the frame tick.
- `mouse_xpos` in 12: mouse X, pclk-synchronous.
- `mouse_ypos` in 12: mouse Y, pclk-synchronous.
- `mouse_left` in 1: left button level, pclk-synchronous.
- `xpos` out 12: registered rectangle X.
- `ypos` out 12: registered rectangle Y.
- `busy` out 1: registered; high in FALL or RISE.

## Operation
- Frame tick: `tick = vblnk_in & ~vblnk_prev`.
- Click: `click = mouse_left & ~left_prev`.
- Velocity `vel`: unsigned 8-bit magnitude, px/frame.
- State machine states: IDLE, FALL, RISE, REST. The RISE state only exists with `BOUNCE_EN`.
- IDLE:
  - On tick: `xpos <= mouse_xpos`; `ypos <= min(mouse_ypos, FLOOR)`.
  - On click: go to FALL with `vel <= 0`, without waiting for a tick.
  - If tick and click occur in the same cycle, both the position update and the transition happen.
- FALL, on tick:
  - `v = min(vel + ACCEL, VMAX)`; `y = ypos + v`, computed 13-bit so it cannot overflow.
  - If `y < FLOOR`: `ypos <= y`, `vel <= v`.
  - Otherwise (floor hit): `ypos <= FLOOR`, then apply the floor rule from Configuration.
- RISE, on tick:
  - `ypos <= (vel > ypos) ? 0 : ypos - vel`.
  - `vel <= (vel > ACCEL) ? vel - ACCEL : 0`.
  - When the new `vel` is 0, go to FALL.
- REST: position held. On click, go to IDLE; tracking resumes at the next tick.
- `xpos` is frozen in FALL, RISE and REST.
- Clicks in FALL and RISE are ignored.
- Between ticks, all state is stable.

## Timing
- Reset values: `xpos = 0`, `ypos = 0`, `busy = 0`, `vel = 0`, state IDLE.
- `vblnk_prev` and `left_prev` reset to 1. This suppresses a spurious tick or click if an input is already high when reset is released.
- Latency:
  - Outputs change at the same edge that first samples `vblnk_in` high, i.e. one pclk after `vblnk_in` rises, while still inside blanking.
  - The click transition happens at the edge that first samples `mouse_left` high; `busy` rises on that edge.
- Exactly one update per frame. `vblnk_in` staying high produces no further ticks.
- Reset asserted mid-fall overrides everything, including a tick in the same cycle.

## Configuration
- `DRAW_RECT_BOUNCE_EN` defined, floor hit:
  - `vb = v - (v >> 2)`.
  - If `vb >= MIN_BOUNCE`: go to RISE with `vel <= vb`.
  - Otherwise: go to REST with `vel <= 0`.
- `DRAW_RECT_BOUNCE_EN` undefined: a floor hit always goes to REST with `vel <= 0`. The RISE state and its logic are not compiled.

## Test plan
- Reset release with `vblnk_in` high and `mouse_left` high -> no tick, no click; outputs stay 0/0; `busy = 0`.
- IDLE tracking, mouse at (300, 700), one vblank edge -> `xpos = 300`, `ypos = 536` (clamped); no change for the rest of the blanking interval.
- Drop, no bounce, from `ypos = 500`:
  - Click -> `busy = 1`.
  - Ticks give `ypos` 501, 503, 506, 510, 515, 521, 528, 536.
  - After the 8th tick, REST with `busy = 0`; `xpos` is unchanged throughout.
- Bounce, same drop with `DRAW_RECT_BOUNCE_EN`:
  - 8th tick -> RISE with `vel = 6`.
  - Following ticks give `ypos` 530, 525, 521, 518, 516, 515, then back to FALL.
  - Next floor hit at `vel = 6` -> RISE with `vel = 5`.
- Saturation, drop from `ypos = 0`:
  - After 32 ticks, `ypos = 528` and `vel = 32`.
  - Tick 33 -> `ypos = 536`; with bounce enabled, RISE with `vel = 24`.
- Click during FALL is ignored. Click in REST -> IDLE, and the next tick loads the mouse position. Reset asserted mid-FALL, coincident with a tick -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl - frame-rate motion controller for the sprite rectangle.
//
// Produces the xpos/ypos pair for the rectangle draw stage. In IDLE the
// rectangle follows the mouse. A left click drops it under constant per-frame
// acceleration to the floor (SCREEN_H - RECT_H). Every position update is
// applied on the rising edge of vertical blanking only.
//
// Build option: define DRAW_RECT_BOUNCE_EN to make floor hits bounce with a
// 25% velocity loss. Without it, a floor hit always comes to rest.
//
// Ports:
//   pclk        in   pixel clock, rising edge
//   rst         in   synchronous active-high reset
//   vblnk_in    in   vertical blanking; its rising edge is the frame tick
//   mouse_xpos  in   [11:0] mouse X
//   mouse_ypos  in   [11:0] mouse Y
//   mouse_left  in   left button level
//   xpos        out  [11:0] registered rectangle X
//   ypos        out  [11:0] registered rectangle Y
//   busy        out  registered, high while falling or rising
module draw_rect_ctl #(
    parameter int SCREEN_H   = 600,
    parameter int RECT_H     = 64,
    parameter int ACCEL      = 1,
    parameter int VMAX       = 32,
    parameter int MIN_BOUNCE = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy
);

    localparam logic [11:0] FLOOR    = 12'(SCREEN_H - RECT_H);
    localparam logic [8:0]  LP_ACCEL = 9'(ACCEL);
    localparam logic [8:0]  LP_VMAX  = 9'(VMAX);

`ifdef DRAW_RECT_BOUNCE_EN
    localparam logic [7:0]  LP_MIN_BOUNCE = 8'(MIN_BOUNCE);
    typedef enum logic [1:0] {S_IDLE, S_FALL, S_RISE, S_REST} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FALL, S_REST} state_t;
`endif

    state_t      r_state, w_state_nx;
    logic [7:0]  r_vel, w_vel_nx;
    logic [11:0] r_xpos, w_xpos_nx;
    logic [11:0] r_ypos, w_ypos_nx;
    logic        r_busy, w_busy_nx;
    logic        r_vblnk_prev;
    logic        r_left_prev;

    logic        w_tick;
    logic        w_click;
    logic [8:0]  w_vsum;
    logic [7:0]  w_v;
    logic [12:0] w_y13;

    assign w_tick  = vblnk_in & ~r_vblnk_prev;
    assign w_click = mouse_left & ~r_left_prev;

    // Falling step: saturating velocity, then a 13-bit sum so the floor
    // compare never wraps.
    assign w_vsum = {1'b0, r_vel} + LP_ACCEL;
    assign w_v    = (w_vsum > LP_VMAX) ? LP_VMAX[7:0] : w_vsum[7:0];
    assign w_y13  = {1'b0, r_ypos} + {5'b0, w_v};

`ifdef DRAW_RECT_BOUNCE_EN
    logic [7:0]  w_vb;
    logic [7:0]  w_vel_dec;

    assign w_vb      = w_v - (w_v >> 2);
    assign w_vel_dec = ({1'b0, r_vel} > LP_ACCEL) ? (r_vel - LP_ACCEL[7:0]) : '0;
`endif

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vel        <= '0;
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_busy       <= 1'b0;
            r_vblnk_prev <= 1'b1;
            r_left_prev  <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_vel        <= w_vel_nx;
            r_xpos       <= w_xpos_nx;
            r_ypos       <= w_ypos_nx;
            r_busy       <= w_busy_nx;
            r_vblnk_prev <= vblnk_in;
            r_left_prev  <= mouse_left;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_vel_nx   = r_vel;
        w_xpos_nx  = r_xpos;
        w_ypos_nx  = r_ypos;

        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_xpos_nx = mouse_xpos;
                    w_ypos_nx = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
                end
                // Click does not wait for a tick; a coincident tick still
                // loads the mouse position above.
                if (w_click) begin
                    w_state_nx = S_FALL;
                    w_vel_nx   = '0;
                end
            end

            S_FALL: begin
                if (w_tick) begin
                    if (w_y13 < {1'b0, FLOOR}) begin
                        w_ypos_nx = w_y13[11:0];
                        w_vel_nx  = w_v;
                    end else begin
                        w_ypos_nx = FLOOR;
`ifdef DRAW_RECT_BOUNCE_EN
                        if (w_vb >= LP_MIN_BOUNCE) begin
                            w_state_nx = S_RISE;
                            w_vel_nx   = w_vb;
                        end else begin
                            w_state_nx = S_REST;
                            w_vel_nx   = '0;
                        end
`else
                        w_state_nx = S_REST;
                        w_vel_nx   = '0;
`endif
                    end
                end
            end

`ifdef DRAW_RECT_BOUNCE_EN
            S_RISE: begin
                if (w_tick) begin
                    w_ypos_nx = ({4'b0, r_vel} > r_ypos) ? '0 : (r_ypos - {4'b0, r_vel});
                    w_vel_nx  = w_vel_dec;
                    if (w_vel_dec == '0) begin
                        w_state_nx = S_FALL;
                    end
                end
            end
`endif

            S_REST: begin
                if (w_click) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

`ifdef DRAW_RECT_BOUNCE_EN
        w_busy_nx = (w_state_nx == S_FALL) || (w_state_nx == S_RISE);
`else
        w_busy_nx = (w_state_nx == S_FALL);
`endif
    end

    assign xpos = r_xpos;
    assign ypos = r_ypos;
    assign busy = r_busy;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Testbench for draw_rect_ctl: directed sequence plus randomized steps,
// checked against a per-frame behavioural model of the rectangle motion.
module tb_draw_rect_ctl;

    localparam int FLOOR      = 536;
    localparam int ACCEL      = 1;
    localparam int VMAX       = 32;
    localparam int MIN_BOUNCE = 4;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    typedef enum {M_TRACK, M_DROP, M_UP, M_STILL} mode_t;
    mode_t m_mode;
    int    m_x, m_y, m_vel;

    draw_rect_ctl dut (
        .pclk       (pclk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .mouse_left (mouse_left),
        .xpos       (xpos),
        .ypos       (ypos),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".x"}, {20'b0, xpos}, m_x);
        check({tag, ".y"}, {20'b0, ypos}, m_y);
        check({tag, ".busy"}, {31'b0, busy}, ((m_mode == M_DROP) || (m_mode == M_UP)) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_mode = M_TRACK;
        m_x    = 0;
        m_y    = 0;
        m_vel  = 0;
    endtask

    // One sampled edge worth of behaviour, given which edges occurred.
    task automatic model_step(input bit tick, input bit click);
        int v, y, vb;
        case (m_mode)
            M_TRACK: begin
                if (tick) begin
                    m_x = int'(mouse_xpos);
                    m_y = (int'(mouse_ypos) > FLOOR) ? FLOOR : int'(mouse_ypos);
                end
                if (click) begin
                    m_mode = M_DROP;
                    m_vel  = 0;
                end
            end
            M_DROP: if (tick) begin
                v = m_vel + ACCEL;
                if (v > VMAX) v = VMAX;
                y = m_y + v;
                if (y < FLOOR) begin
                    m_y   = y;
                    m_vel = v;
                end else begin
                    m_y = FLOOR;
`ifdef DRAW_RECT_BOUNCE_EN
                    vb = v - v / 4;
                    if (vb >= MIN_BOUNCE) begin
                        m_mode = M_UP;
                        m_vel  = vb;
                    end else begin
                        m_mode = M_STILL;
                        m_vel  = 0;
                    end
`else
                    vb     = 0;
                    m_mode = M_STILL;
                    m_vel  = vb;
`endif
                end
            end
            M_UP: if (tick) begin
                m_y   = (m_vel > m_y) ? 0 : m_y - m_vel;
                m_vel = (m_vel > ACCEL) ? m_vel - ACCEL : 0;
                if (m_vel == 0) m_mode = M_DROP;
            end
            M_STILL: if (click) m_mode = M_TRACK;
            default: ;
        endcase
    endtask

    // Called #1 after a posedge with vblnk_in and mouse_left low.
    task automatic step(input bit tick, input bit click, input string tag);
        vblnk_in   = tick;
        mouse_left = click;
        @(posedge pclk); #1;
        model_step(tick, click);
        check_outputs(tag);
        repeat (3) begin
            mouse_xpos = 12'($urandom);
            mouse_ypos = 12'($urandom_range(0, 800));
            @(posedge pclk); #1;
        end
        check_outputs({tag, ".hold"});
        vblnk_in   = 1'b0;
        mouse_left = 1'b0;
        repeat (2) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic set_mouse(input int x, input int y);
        mouse_xpos = 12'(x);
        mouse_ypos = 12'(y);
    endtask

    task automatic run_to_rest(input string tag);
        for (int k = 0; k < 300 && m_mode != M_STILL; k++) step(1'b1, 1'b0, tag);
        check({tag, ".rest_busy"}, {31'b0, busy}, 0);
    endtask

    int exp_fall[8] = '{501, 503, 506, 510, 515, 521, 528, 536};
`ifdef DRAW_RECT_BOUNCE_EN
    int exp_rise[6]  = '{530, 525, 521, 518, 516, 515};
    int exp_fall2[6] = '{516, 518, 521, 525, 530, 536};
`endif

    initial begin
        // Reset with blanking and button already high: no tick, no click.
        rst        = 1'b1;
        vblnk_in   = 1'b1;
        mouse_left = 1'b1;
        set_mouse(300, 700);
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge pclk); #1;
        end
        check_outputs("reset");
        vblnk_in   = 1'b0;
        mouse_left = 1'b0;
        repeat (2) begin
            @(posedge pclk); #1;
        end
        check_outputs("reset_low");

        // Tracking with clamp.
        set_mouse(300, 700);
        step(1'b1, 1'b0, "track");
        check("track_x_const", {20'b0, xpos}, 300);
        check("track_y_clamp", {20'b0, ypos}, 536);

        // Drop from 500.
        set_mouse(123, 500);
        step(1'b1, 1'b0, "load500");
        check("load500_y", {20'b0, ypos}, 500);
        step(1'b0, 1'b1, "click");
        check("click_busy", {31'b0, busy}, 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, "fall");
            check("fall_seq", {20'b0, ypos}, exp_fall[i]);
            check("fall_x_frozen", {20'b0, xpos}, 123);
        end
`ifdef DRAW_RECT_BOUNCE_EN
        check("bounce_busy", {31'b0, busy}, 1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, "rise");
            check("rise_seq", {20'b0, ypos}, exp_rise[i]);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, "fall2");
            check("fall2_seq", {20'b0, ypos}, exp_fall2[i]);
        end
        step(1'b1, 1'b0, "rise_v5");
        check("rise_v5_y", {20'b0, ypos}, 531);
        run_to_rest("drop500");
`else
        check("rest_busy", {31'b0, busy}, 0);
`endif
        check("drop500_x", {20'b0, xpos}, 123);

        // Click in REST returns to tracking; next tick loads the mouse.
        set_mouse(77, 200);
        step(1'b0, 1'b1, "rest_click");
        check("rest_click_y_held", {20'b0, ypos}, 536);
        set_mouse(77, 200);
        step(1'b1, 1'b0, "resume");
        check("resume_x", {20'b0, xpos}, 77);
        check("resume_y", {20'b0, ypos}, 200);

        // Saturation from 0, with ignored clicks during the fall.
        set_mouse(9, 0);
        step(1'b1, 1'b0, "load0");
        step(1'b0, 1'b1, "click0");
        for (int i = 0; i < 32; i++) begin
            if (i == 10) step(1'b0, 1'b1, "fall_click");
            step(1'b1, (i == 20), "sat");
        end
        check("sat_y32", {20'b0, ypos}, 528);
        step(1'b1, 1'b0, "sat33");
        check("sat_y33", {20'b0, ypos}, 536);
`ifdef DRAW_RECT_BOUNCE_EN
        step(1'b1, 1'b0, "sat_rise");
        check("sat_rise_v24", {20'b0, ypos}, 512);
        run_to_rest("sat");
`else
        check("sat_rest_busy", {31'b0, busy}, 0);
`endif

        // Back to tracking, coincident tick and click in IDLE.
        step(1'b0, 1'b1, "rest_click2");
        set_mouse(400, 300);
        step(1'b1, 1'b1, "tick_click");
        check("tick_click_y", {20'b0, ypos}, 300);
        check("tick_click_busy", {31'b0, busy}, 1);
        repeat (3) step(1'b1, 1'b0, "pre_rst_fall");

        // Reset mid-fall, coincident with a tick.
        rst      = 1'b1;
        vblnk_in = 1'b1;
        @(posedge pclk); #1;
        model_reset();
        check_outputs("rst_mid");
        rst = 1'b0;
        @(posedge pclk); #1;
        check_outputs("rst_mid_after");
        vblnk_in = 1'b0;
        repeat (2) begin
            @(posedge pclk); #1;
        end
        set_mouse(55, 66);
        step(1'b1, 1'b0, "rst_track");
        check("rst_track_x", {20'b0, xpos}, 55);

        // Randomized steps against the model.
        for (int i = 0; i < 150; i++) begin
            set_mouse(int'($urandom_range(0, 4095)), int'($urandom_range(0, 800)));
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
